// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bundled fetch, load/store and memory-port signals for mem_port_arbiter
//
// Purpose: groups every handshake/bus signal of the arbiter so the core and the
// bench connect through one object.
//   slave  modport : the arbiter's view (requests/mem_ready/mem_rdata in, rest out)
//   master modport : the core + memory side (drives requests and memory response)
// Signals:
//   if_req/if_addr -> if_rvalid/if_rdata        instruction fetch
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata -> d_done/d_rdata/d_err   load/store
//   stall                                       either requester waiting
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ready/mem_rdata      memory port

interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic          d_unsigned;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_done;
  logic [31:0]   d_rdata;
  logic          d_err;

  logic          stall;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rvalid, if_rdata,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_done, d_rdata, d_err,
    output stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rvalid, if_rdata,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_done, d_rdata, d_err,
    input  stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for instruction fetch and load/store
//
// Purpose: shares one unified single-port memory between fetch and the data path.
// An IDLE/FETCH/DATA FSM picks one requester per access; a run counter forces
// fetch to win after MAX_DATA_RUN consecutive data grants while fetch waits.
// Stores get lane-replicated data and byte enables; loads are aligned and
// sign/zero extended. Misaligned data accesses complete with d_err and never
// reach memory.
// Ports:
//   i_clk    in  clock, rising edge
//   i_rst_n  in  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave (fetch, load/store, stall, memory port)

module mem_port_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int AW           = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mem_port_arbiter_if.slave     bus
);

  localparam int RW = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t        r_state, w_state_n;
  logic [RW-1:0] r_run, w_run_n;

  logic          r_mem_req,   w_mem_req_n;
  logic          r_mem_we,    w_mem_we_n;
  logic [AW-1:0] r_mem_addr,  w_mem_addr_n;
  logic [31:0]   r_mem_wdata, w_mem_wdata_n;
  logic [3:0]    r_mem_be,    w_mem_be_n;

  logic          r_if_rvalid, w_if_rvalid_n;
  logic [31:0]   r_if_rdata,  w_if_rdata_n;
  logic          r_d_done,    w_d_done_n;
  logic          r_d_err,     w_d_err_n;
  logic [31:0]   r_d_rdata,   w_d_rdata_n;

  // Load shape captured at grant, since the requester may (illegally) drop
  // or change its inputs while the access is in flight.
  logic [1:0]    r_lane,     w_lane_n;
  logic [1:0]    r_size,     w_size_n;
  logic          r_unsigned, w_unsigned_n;

  logic          w_misaligned;
  logic          w_data_win;
  logic [31:0]   w_st_wdata;
  logic [3:0]    w_st_be;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic [AW-1:0] w_word_mask;

  assign w_word_mask = ~(AW'(3));

  // d_size 11 is treated like a word access.
  assign w_misaligned = (bus.d_size == 2'b01 && bus.d_addr[0]) ||
                        (bus.d_size[1] && bus.d_addr[1:0] != 2'b00);

  // Data wins unless fetch is waiting and data has used up its run budget.
  assign w_data_win = bus.d_req && (!bus.if_req || r_run < RW'(MAX_DATA_RUN));

  always_comb begin
    w_st_wdata = bus.d_wdata;
    w_st_be    = 4'b1111;
    case (bus.d_size)
      2'b00: begin
        w_st_wdata = {4{bus.d_wdata[7:0]}};
        w_st_be    = 4'b0001 << bus.d_addr[1:0];
      end
      2'b01: begin
        w_st_wdata = {2{bus.d_wdata[15:0]}};
        w_st_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = bus.d_wdata;
        w_st_be    = 4'b1111;
      end
    endcase
  end

  assign w_shift = bus.mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    w_load = bus.mem_rdata;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load = r_unsigned ? {16'd0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_run_n       = r_run;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_be_n    = r_mem_be;
    w_if_rvalid_n = 1'b0;
    w_if_rdata_n  = r_if_rdata;
    w_d_done_n    = 1'b0;
    w_d_err_n     = 1'b0;
    w_d_rdata_n   = r_d_rdata;
    w_lane_n      = r_lane;
    w_size_n      = r_size;
    w_unsigned_n  = r_unsigned;

    case (r_state)
      S_IDLE: begin
        if (bus.d_req && w_misaligned) begin
          // Error completion without touching memory; run is left alone.
          w_d_done_n = 1'b1;
          w_d_err_n  = 1'b1;
        end else if (w_data_win) begin
          w_state_n     = S_DATA;
          w_run_n       = bus.if_req ? r_run + RW'(1) : '0;
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = bus.d_we;
          w_mem_addr_n  = bus.d_addr & w_word_mask;
          w_mem_wdata_n = bus.d_we ? w_st_wdata : 32'd0;
          w_mem_be_n    = bus.d_we ? w_st_be : 4'b0000;
          w_lane_n      = bus.d_addr[1:0];
          w_size_n      = bus.d_size;
          w_unsigned_n  = bus.d_unsigned;
        end else if (bus.if_req) begin
          w_state_n     = S_FETCH;
          w_run_n       = '0;
          w_mem_req_n   = 1'b1;
          w_mem_we_n    = 1'b0;
          w_mem_addr_n  = bus.if_addr & w_word_mask;
          w_mem_wdata_n = 32'd0;
          w_mem_be_n    = 4'b0000;
        end
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_state_n     = S_IDLE;
          w_mem_req_n   = 1'b0;
          w_mem_we_n    = 1'b0;
          w_mem_be_n    = 4'b0000;
          w_if_rvalid_n = 1'b1;
          w_if_rdata_n  = bus.mem_rdata;
        end
      end
      S_DATA: begin
        if (bus.mem_ready) begin
          w_state_n   = S_IDLE;
          w_mem_req_n = 1'b0;
          w_mem_we_n  = 1'b0;
          w_mem_be_n  = 4'b0000;
          w_d_done_n  = 1'b1;
          w_d_rdata_n = r_mem_we ? 32'd0 : w_load;
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_mem_req_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_run       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_done    <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
      r_lane      <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_run       <= w_run_n;
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_be    <= w_mem_be_n;
      r_if_rvalid <= w_if_rvalid_n;
      r_if_rdata  <= w_if_rdata_n;
      r_d_done    <= w_d_done_n;
      r_d_err     <= w_d_err_n;
      r_d_rdata   <= w_d_rdata_n;
      r_lane      <= w_lane_n;
      r_size      <= w_size_n;
      r_unsigned  <= w_unsigned_n;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;

  assign bus.stall = (bus.if_req & ~r_if_rvalid) | (bus.d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
  } d_exp_t;

  d_exp_t      d_q[$];
  logic [31:0] if_q[$];
  logic [7:0]  grant_q[$];

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(.MAX_DATA_RUN(4), .AW(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'd0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_size     = 2'b00;
    bus.d_unsigned = 1'b0;
    bus.d_addr     = 32'd0;
    bus.d_wdata    = 32'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.if_rvalid !== 1'b0) begin bad++; $display("FAIL reset_if_rvalid got=%b want=0", bus.if_rvalid); end
    total++; if (bus.d_done !== 1'b0 || bus.d_err !== 1'b0) begin bad++; $display("FAIL reset_d_done_err got=%b%b want=00", bus.d_done, bus.d_err); end
    total++; if (bus.mem_be !== 4'b0000 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_be_we got=%b/%b want=0000/0", bus.mem_be, bus.mem_we); end
    total++; if (bus.d_rdata !== 32'd0 || bus.if_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", bus.d_rdata, bus.if_rdata); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00500093;
    if_q.push_back(32'h00500093);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_n got=%b want=1", bus.stall); end
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_mem_n1 got=%b/%h want=1/00000100", bus.mem_req, bus.mem_addr); end
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_n1 got=%b want=1", bus.stall); end
    @(negedge clk);
    total++;
    if (bus.if_rvalid !== 1'b1) begin
      bad++; $display("FAIL fetch_rvalid_n2 got=%b want=1", bus.if_rvalid);
    end else begin
      e = if_q.pop_front();
      total++; if (bus.if_rdata !== e) begin bad++; $display("FAIL fetch_rdata got=%h want=%h", bus.if_rdata, e); end
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width got=%b want=0", bus.if_rvalid); end
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] want);
    d_exp_t e;
    bus.d_req      = 1'b1;
    bus.d_we       = 1'b0;
    bus.d_size     = 2'b00;
    bus.d_unsigned = uns;
    bus.d_addr     = 32'h203;
    bus.mem_ready  = 1'b1;
    bus.mem_rdata  = 32'h80FF1234;
    d_q.push_back('{err: 1'b0, chk: 1'b1, data: want});
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_be !== 4'b0000 || bus.mem_we !== 1'b0)
      begin bad++; $display("FAIL load_mem got=%b/%h/%b/%b want=1/00000200/0000/0", bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_we); end
    @(negedge clk);
    total++;
    if (bus.d_done !== 1'b1) begin
      bad++; $display("FAIL load_done got=%b want=1", bus.d_done);
    end else begin
      e = d_q.pop_front();
      total++; if (bus.d_rdata !== e.data || bus.d_err !== e.err) begin bad++; $display("FAIL load_rdata_u%0d got=%h/%b want=%h/%b", uns, bus.d_rdata, bus.d_err, e.data, e.err); end
    end
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL load_pulse_width got=%b want=0", bus.d_done); end
  endtask

  task automatic test_store_half();
    d_exp_t e;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_size    = 2'b01;
    bus.d_addr    = 32'h42;
    bus.d_wdata   = 32'h0000BEEF;
    bus.mem_ready = 1'b0;
    d_q.push_back('{err: 1'b0, chk: 1'b0, data: 32'd0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b1100 ||
          bus.mem_wdata !== 32'hBEEFBEEF || bus.mem_addr !== 32'h40 || bus.d_done !== 1'b0) begin
        bad++;
        $display("FAIL store_hold_%0d got=%b/%b/%b/%h/%h/%b want=1/1/1100/beefbeef/00000040/0",
                 i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr, bus.d_done);
      end
      if (i == 3) bus.mem_ready = 1'b1;
    end
    @(negedge clk);
    total++;
    if (bus.d_done !== 1'b1 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL store_done got=%b/%b want=1/0", bus.d_done, bus.mem_req);
    end else begin
      e = d_q.pop_front();
      total++; if (bus.d_err !== e.err) begin bad++; $display("FAIL store_err got=%b want=%b", bus.d_err, e.err); end
    end
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    d_exp_t e;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_size    = 2'b10;
    bus.d_addr    = 32'h6;
    bus.mem_ready = 1'b1;
    d_q.push_back('{err: 1'b1, chk: 1'b0, data: 32'd0});
    @(negedge clk);
    total++;
    if (bus.d_done !== 1'b1) begin
      bad++; $display("FAIL misalign_done got=%b want=1", bus.d_done);
    end else begin
      e = d_q.pop_front();
      total++; if (bus.d_err !== e.err) begin bad++; $display("FAIL misalign_err got=%b want=%b", bus.d_err, e.err); end
    end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL misalign_mem_req got=%b want=0", bus.mem_req); end
    bus.d_req = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b0 || bus.d_done !== 1'b0) begin bad++; $display("FAIL misalign_quiet got=%b/%b want=0/0", bus.mem_req, bus.d_done); end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_starvation();
    logic [7:0] g;
    logic [7:0] want;
    int         seen;
    seen = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) grant_q.push_back("D");
      grant_q.push_back("F");
    end
    bus.if_addr   = 32'h1000;
    bus.d_addr    = 32'h2000;
    bus.d_size    = 2'b10;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h13;
    bus.if_req    = 1'b1;
    bus.d_req     = 1'b1;
    for (int c = 0; c < 60 && grant_q.size() != 0; c++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        g    = (bus.mem_addr == 32'h1000) ? "F" : "D";
        want = grant_q.pop_front();
        total++; if (g !== want) begin bad++; $display("FAIL starve_grant_%0d got=%s want=%s", seen, g, want); end
        seen++;
      end
    end
    total++; if (grant_q.size() != 0) begin bad++; $display("FAIL starve_timeout got=%0d want=10 grants", seen); end
    grant_q.delete();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    logic [31:0] e;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_size    = 2'b10;
    bus.d_addr    = 32'h300;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b want=1", bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b want=0", bus.mem_req); end
    bus.d_req = 1'b0;
    @(negedge clk);
    total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", bus.d_done); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.d_done !== 1'b0 || bus.mem_req !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b/%b want=0/0", bus.d_done, bus.mem_req); end
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h400;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h12345678;
    if_q.push_back(32'h12345678);
    @(negedge clk);
    total++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin bad++; $display("FAIL rstmid_fetch_mem got=%b/%h want=1/00000400", bus.mem_req, bus.mem_addr); end
    @(negedge clk);
    total++;
    if (bus.if_rvalid !== 1'b1) begin
      bad++; $display("FAIL rstmid_fetch_rvalid got=%b want=1", bus.if_rvalid);
    end else begin
      e = if_q.pop_front();
      total++; if (bus.if_rdata !== e) begin bad++; $display("FAIL rstmid_fetch_rdata got=%h want=%h", bus.if_rdata, e); end
    end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_store_half();
    test_misaligned();
    test_starvation();
    test_reset_mid_data();
    total++; if (d_q.size() != 0 || if_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", d_q.size(), if_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch and the load/store path of the riscv32i core.
- Holds a small FSM that arbitrates between the two requesters with a starvation guard.
- Drives a ready-handshaked memory port and generates byte enables for stores.
- Aligns and extends load data (lb/lh/lbu/lhu/lw), and raises stall while either requester is waiting.

Parameters:
- MAX_DATA_RUN, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_rvalid.
- if_addr  in  AW  fetch address, word aligned.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  load/store request; held until d_done.
- d_we  in  1  1 = store.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_unsigned  in  1  zero-extend loads.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data, LSB-justified.
- d_done  out  1  one-cycle completion pulse (load data valid, store retired, or error).
- d_rdata  out  32  aligned, extended load data.
- d_err  out  1  misalignment, valid with d_done.
- stall  out  1  combinational: (if_req & ~if_rvalid) | (d_req & ~d_done).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  AW  word address {addr[AW-1:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables (0000 on reads).
- mem_ready  in  1  access completes this cycle; mem_rdata valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (async, immediate): state IDLE; run counter 0; every output 0; mem_req drops in the same instant even mid-access; no completion pulse is issued for the aborted access.
- States: IDLE, FETCH, DATA.
- IDLE arbitration, evaluated each cycle:
  - d_req with misaligned access (half with addr[0]=1, word with addr[1:0]!=0): issue a d_done+d_err pulse next cycle; no memory access; run counter unchanged; stay IDLE.
  - d_req and (~if_req or run<MAX_DATA_RUN) -> DATA; run++ if if_req, else run=0.
  - Otherwise if_req -> FETCH; run=0.
- Registered outputs: mem_req and address/we/be/wdata are registered on entry to FETCH/DATA and held stable until mem_ready.
  - Minimum latency: request in IDLE at cycle N; mem_req high at N+1; mem_ready at N+1 gives if_rvalid/d_done at N+2.
  - Responses are registered; state returns to IDLE on the mem_ready cycle.
  - Back-to-back: new arbitration at N+2, so the maximum rate is one access per 2 cycles.
- Store lanes:
  - byte: wdata={4{b}}, be=0001<<addr[1:0].
  - half: wdata={2{h}}, be=addr[1]?1100:0011.
  - word: be=1111.
- Load extraction: shift mem_rdata right by 8*addr[1:0]; take byte/half; sign-extend unless d_unsigned; word passes through.
- Requester rules:
  - A requester that drops its request before completion is a protocol violation; the access still completes and the pulse is still issued.
  - Simultaneous if_req and d_req with run=MAX_DATA_RUN: fetch wins and run clears.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset mid-DATA (mem_req=1, mem_ready=0), deassert rst_n -> mem_req=0 asynchronously; no d_done; after release, IDLE; next fetch completes in 2 cycles.
- Fetch alone at if_addr=0x100, mem_ready tied 1, mem_rdata=0x00500093 -> mem_addr=0x100 at N+1; if_rvalid=1, if_rdata=0x00500093 at N+2; stall high N..N+1.
- Load byte signed, d_addr=0x203, mem_rdata=0x80FF1234 -> mem_addr=0x200, mem_be=0000, d_rdata=0xFFFFFF80; same access with d_unsigned=1 -> 0x00000080.
- Store half, d_addr=0x42, d_wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x40; mem_ready delayed 3 cycles -> signals held stable, d_done one cycle after mem_ready.
- Misaligned word load at 0x6 -> d_done=d_err=1 next cycle; mem_req never asserted.
- if_req and d_req held continuously, MAX_DATA_RUN=4 -> grant sequence D,D,D,D,F repeating; fetch never starved beyond 4 data accesses.
